adder_rr_scheduler: RTL
=======================

// Module: adder_rr_scheduler
// PURPOSE
//  Shares one registered ADDER_WIDTH-bit adder between NUM_REQ requesters.
//  - Round-robin arbiter grants one operand pair per cycle.
//  - Two-stage pipeline: operand register, then sum register. Full carry-out.
//  - Each result returns tagged with the requester ID, under valid/ready backpressure.
//  - Sits between client datapaths and the adder; the adder is instantiated nowhere else.
// PARAMETERS
//  ADDER_WIDTH  111  operand width; sum is ADDER_WIDTH+1 bits
//  NUM_REQ      4    number of requesters, >=2
//  ID_W         $clog2(NUM_REQ)  requester tag width (localparam, not overridable)
//  CNT_W        32   completed-operation counter width
// PORTS
//  clk        in   1                    rising-edge clock, single domain
//  rst_n      in   1                    asynchronous active-low reset
//  req_valid  in   NUM_REQ              per-requester operand valid
//  req_ready  out  NUM_REQ              per-requester accept (one-hot or zero)
//  req_a      in   NUM_REQ*ADDER_WIDTH  packed operand A; slice i belongs to requester i
//  req_b      in   NUM_REQ*ADDER_WIDTH  packed operand B; slice i belongs to requester i
//  rsp_valid  out  1                    result valid
//  rsp_ready  in   1                    consumer accepts result
//  rsp_id     out  ID_W                 requester index of this result
//  rsp_sum    out  ADDER_WIDTH+1        a+b with carry in MSB
//  ops_done   out  CNT_W                results handed off since reset; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async assert, sync release): rsp_valid=0, rsp_id=0, rsp_sum=0,
//   ops_done=0, s1_valid=0, rr_ptr=0. In-flight operations are discarded, not replayed.
//  Handshakes:
//   - Transfer on valid&&ready.
//   - Requester holds a/b stable while valid && !ready.
//   - rsp_id/rsp_sum are held stable while rsp_valid && !rsp_ready.
//  Pipeline:
//   - out_free = !rsp_valid || rsp_ready.
//   - s1_free  = !s1_valid  || out_free.
//  Arbitration (combinational):
//   - When s1_free=1, grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - req_ready[i] = grant[i]. When s1_free=0, req_ready is all zero.
//   - req_ready depends combinationally on req_valid. Consumers must not gate valid on ready.
//  Stage 1, on grant:
//   - s1_a<=req_a[i], s1_b<=req_b[i], s1_id<=i, s1_valid<=1.
//   - rr_ptr<=(i+1) mod NUM_REQ.
//   - If s1_free with no grant: s1_valid<=0, rr_ptr unchanged.
//  Stage 2, on out_free:
//   - rsp_valid<=s1_valid. If s1_valid: rsp_sum<={1'b0,s1_a}+{1'b0,s1_b}, rsp_id<=s1_id.
//  Latency and throughput:
//   - Accept edge to rsp_valid is 2 clk cycles.
//   - Throughput 1 op/cycle with no backpressure.
//   - Capacity 2 ops in flight; no combinational path from rsp_ready to req_ready beyond s1_free.
//  ops_done increments on every rsp_valid&&rsp_ready cycle.
//  Boundaries:
//   - Simultaneous accept and output handoff in the same cycle is legal (pipeline advances).
//   - Stall while full: both stages hold, all req_ready=0, rr_ptr frozen.
//   - Single active requester gets every slot; rr_ptr never skips a waiting requester.
//   - Carry: all-ones + 1 sets rsp_sum[ADDER_WIDTH].
// STRUCTURE
//  - Package adder_sched_pkg: ADDER_WIDTH default, id_width() function, ops_cnt_t typedef.
//  - Sub-module rr_arbiter (NUM_REQ): inputs req, ptr, enable; outputs grant one-hot and grant_idx.
//  - Top level holds the pipeline registers, rr_ptr and ops_done.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> rsp_valid=0 and ops_done=0 immediately; no stale result after release.
//  2 Single op: req0 a=5 b=7, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_sum=12, rsp_id=0.
//  3 Carry: a=2^111-1, b=1 -> rsp_sum=2^111 (bit 111 only); a=b=2^111-1 -> 2^112-2.
//  4 Fairness: all 4 valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; ops_done=8 after drain.
//  5 Backpressure: rsp_ready=0 for 5 cycles with req1,req2 valid -> 2 ops captured, then req_ready=0.
//    Release -> results id1 then id2, values intact, none lost or duplicated.
//  6 Sparse: only req3 valid while rr_ptr=0 -> granted same cycle; rr_ptr becomes 0 (wrap).
//  Scoreboard: reference model sums per ID, order-checked; run 10k random valid/ready cycles.

Source files
------------

// File: rtl/adder_sched_pkg.sv
// Shared constants, types and helpers for the round-robin adder scheduler.
// Imported by the scheduler top and its arbiter.
package adder_sched_pkg;
    localparam int ADDER_WIDTH_DEF = 111;
    localparam int CNT_W_DEF       = 32;

    typedef logic [CNT_W_DEF-1:0] ops_cnt_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/adder_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo NUM_REQ. The grant is one-hot, or all zero when disabled or idle.
module rr_arbiter
    import adder_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);
    localparam logic [ID_W:0] NREQ_X = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0] w_pos;
    logic          w_found;

    // One extra bit on w_pos lets ptr+k exceed NUM_REQ-1 before the wrap subtract.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_pos     = '0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_pos = {1'b0, ptr} + (ID_W+1)'(k);
                if (w_pos >= NREQ_X) begin
                    w_pos = w_pos - NREQ_X;
                end
                if (!w_found && req[w_pos[ID_W-1:0]]) begin
                    w_found                  = 1'b1;
                    grant[w_pos[ID_W-1:0]]   = 1'b1;
                    grant_idx                = w_pos[ID_W-1:0];
                end
            end
        end
    end
endmodule

// File: rtl/adder_rr_scheduler.sv
// One shared registered adder time-multiplexed among NUM_REQ requesters.
// Round-robin grant into an operand stage, then a sum stage tagged with the requester id.
module adder_rr_scheduler
    import adder_sched_pkg::*;
#(
    parameter  int ADDER_WIDTH = ADDER_WIDTH_DEF,
    parameter  int NUM_REQ     = 4,
    parameter  int CNT_W       = CNT_W_DEF,
    localparam int ID_W        = id_width(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_W-1:0]                rsp_id,
    output logic [ADDER_WIDTH:0]           rsp_sum,
    output logic [CNT_W-1:0]               ops_done
);
    logic                   r_s1_valid;
    logic [ADDER_WIDTH-1:0] r_s1_a;
    logic [ADDER_WIDTH-1:0] r_s1_b;
    logic [ID_W-1:0]        r_s1_id;
    logic [ID_W-1:0]        r_rr_ptr;
    logic                   r_rsp_valid;
    logic [ID_W-1:0]        r_rsp_id;
    logic [ADDER_WIDTH:0]   r_rsp_sum;
    logic [CNT_W-1:0]       r_ops_done;

    logic                   w_out_free;
    logic                   w_s1_free;
    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_grant_idx;
    logic                   w_grant_any;
    logic [ADDER_WIDTH-1:0] w_sel_a;
    logic [ADDER_WIDTH-1:0] w_sel_b;
    logic [ID_W-1:0]        w_ptr_next;

    // rsp_ready reaches req_ready only through s1_free, never deeper.
    assign w_out_free = !r_rsp_valid || rsp_ready;
    assign w_s1_free  = !r_s1_valid || w_out_free;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (r_rr_ptr),
        .enable    (w_s1_free),
        .grant     (w_grant),
        .grant_idx (w_grant_idx)
    );

    assign w_grant_any = |w_grant;
    assign w_sel_a     = req_a[int'(w_grant_idx)*ADDER_WIDTH +: ADDER_WIDTH];
    assign w_sel_b     = req_b[int'(w_grant_idx)*ADDER_WIDTH +: ADDER_WIDTH];
    assign w_ptr_next  = (w_grant_idx == ID_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;

    // Stage 1: operand register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_rr_ptr   <= '0;
        end else if (w_s1_free) begin
            r_s1_valid <= w_grant_any;
            if (w_grant_any) begin
                r_rr_ptr <= w_ptr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_free && w_grant_any) begin
            r_s1_a  <= w_sel_a;
            r_s1_b  <= w_sel_b;
            r_s1_id <= w_grant_idx;
        end
    end

    // Stage 2: sum register with full carry-out, plus the handoff counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_ops_done  <= '0;
        end else begin
            if (w_out_free) begin
                r_rsp_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_rsp_sum <= {1'b0, r_s1_a} + {1'b0, r_s1_b};
                    r_rsp_id  <= r_s1_id;
                end
            end
            if (r_rsp_valid && rsp_ready) begin
                r_ops_done <= r_ops_done + 1'b1;
            end
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_sum   = r_rsp_sum;
    assign ops_done  = r_ops_done;
endmodule
